// File: rtl/pc_unit_if.sv
// pc_unit_if: request/response bundle between the pipeline control and the PC unit
// Requests to the PC unit: stall, branch_taken/branch_target, trap, halt_req, resume, fetch_ready.
// Responses from the PC unit: pc, pc_next_seq, fetch_valid, epc, misalign, state.
// The PC unit connects through the master modport; the pipeline and test side use slave.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            trap;
  logic            halt_req;
  logic            resume;
  logic            fetch_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next_seq;
  logic            fetch_valid;
  logic [XLEN-1:0] epc;
  logic            misalign;
  logic [1:0]      state;
  modport master (
    input  stall, branch_taken, branch_target, trap, halt_req, resume, fetch_ready,
    output pc, pc_next_seq, fetch_valid, epc, misalign, state
  );
  modport slave (
    output stall, branch_taken, branch_target, trap, halt_req, resume, fetch_ready,
    input  pc, pc_next_seq, fetch_valid, epc, misalign, state
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with boot/run/halt control, branch redirect and trap entry
// Ports: clk (rising-edge clock), rst_n (asynchronous active-low reset),
//   bus (pc_unit_if.master): redirect, trap, halt and flow-control requests in;
//   pc, pc_next_seq, fetch_valid, epc, misalign and state out.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     STEP         = 4
) (
  input logic       clk,
  input logic       rst_n,
  pc_unit_if.master bus
);
  typedef enum logic [1:0] {BOOT = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_t;
  state_t          state, state_n;
  logic [XLEN-1:0] pc, pc_n, epc, epc_n, pc_seq, target;
  logic            mis, mis_n;
  assign pc_seq = pc + XLEN'(STEP);
  assign target = {bus.branch_target[XLEN-1:1], 1'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_VECTOR;
      epc   <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      epc   <= epc_n;
      mis   <= mis_n;
    end
  end
  // A redirect whose bit 1 is set is not word-aligned; it enters the trap
  // vector instead and records the offending target in epc.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    epc_n   = epc;
    mis_n   = 1'b0;
    case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (bus.trap) begin
          pc_n  = TRAP_VECTOR;
          epc_n = pc;
        end else if (bus.branch_taken) begin
          pc_n  = bus.branch_target[1] ? TRAP_VECTOR : target;
          epc_n = bus.branch_target[1] ? target : epc;
          mis_n = bus.branch_target[1];
        end else if (bus.halt_req) begin
          state_n = HALTED;
        end else if (!bus.stall && bus.fetch_ready) begin
          pc_n = pc_seq;
        end
      end
      HALTED: begin
        if (bus.trap) begin
          pc_n    = TRAP_VECTOR;
          epc_n   = pc;
          state_n = RUN;
        end else if (bus.resume && !bus.halt_req) begin
          state_n = RUN;
        end
      end
      default: state_n = BOOT;
    endcase
  end
  assign bus.pc          = pc;
  assign bus.pc_next_seq = pc_seq;
  assign bus.epc         = epc;
  assign bus.misalign    = mis;
  assign bus.state       = state;
  assign bus.fetch_valid = (state == RUN);
endmodule
